// File: rtl/stack_unit.sv
// LIFO stack with a registered top-of-stack, peek capture and sticky overflow/underflow flags.
// The top register mirrors mem[sp-1] so dout is usable on the same edge that pops it.
module stack_unit #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       tos,
  input  logic                       clr,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic [DATA_W-1:0]          peek,
  output logic                       top_zero,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf,
  output logic                       unf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CW-1:0]     sp, sp_nxt, sp_m1, sp_m2;
  logic [DATA_W-1:0] top, top_nxt, peek_r, peek_nxt;
  logic              ovf_r, unf_r, ovf_set, unf_set;
  logic              is_empty, is_full;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;

  assign is_empty = (sp == '0);
  assign is_full  = (sp == CW'(DEPTH));
  assign sp_m1    = sp - CW'(1);
  assign sp_m2    = sp - CW'(2);

  always_comb begin
    sp_nxt   = sp;
    top_nxt  = top;
    peek_nxt = peek_r;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = sp[AW-1:0];

    if (tos) begin
      if (is_empty) begin
        peek_nxt = '0;
        unf_set  = 1'b1;
      end else begin
        peek_nxt = top;
      end
    end

    // Push+pop on a non-empty stack overwrites the top in place, even when full.
    if (push && pop && !is_empty) begin
      wr_en   = 1'b1;
      wr_addr = sp_m1[AW-1:0];
      top_nxt = din;
    end else if (push) begin
      if (is_full) begin
        ovf_set = 1'b1;
      end else begin
        wr_en   = 1'b1;
        wr_addr = sp[AW-1:0];
        top_nxt = din;
        sp_nxt  = sp + CW'(1);
      end
    end else if (pop) begin
      if (is_empty) begin
        unf_set = 1'b1;
      end else if (sp == CW'(1)) begin
        sp_nxt  = '0;
        top_nxt = '0;
      end else begin
        sp_nxt  = sp_m1;
        top_nxt = mem[sp_m2[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp     <= '0;
      top    <= '0;
      peek_r <= '0;
      ovf_r  <= 1'b0;
      unf_r  <= 1'b0;
    end else begin
      sp     <= sp_nxt;
      top    <= top_nxt;
      peek_r <= peek_nxt;
      ovf_r  <= (ovf_r & ~clr) | ovf_set;
      unf_r  <= (unf_r & ~clr) | unf_set;
    end
  end

  // Storage is deliberately not reset; it is unreadable while sp is zero.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_addr] <= din;
  end

  assign dout     = top;
  assign peek     = peek_r;
  assign count    = sp;
  assign empty    = is_empty;
  assign full     = is_full;
  assign top_zero = !is_empty && (top == '0);
  assign ovf      = ovf_r;
  assign unf      = unf_r;

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboarded random and directed test of stack_unit against a queue-based stack model.
module tb_stack_unit;
  localparam int DW = 8;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push = 1'b0, pop = 1'b0, tos = 1'b0, clr = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout, peek;
  logic          top_zero, empty, full, ovf, unf;
  logic [4:0]    count;

  stack_unit #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos), .clr(clr),
    .din(din), .dout(dout), .peek(peek), .top_zero(top_zero), .empty(empty),
    .full(full), .count(count), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dout, peek, tz, em, fu, cnt, ov, un;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: the stack is a queue whose last element is the top.
  int stk[$];
  int m_peek = 0;
  bit m_ovf = 0, m_unf = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    int t;
    t     = (stk.size() == 0) ? 0 : stk[stk.size()-1];
    e.dout = t;
    e.peek = m_peek;
    e.em   = (stk.size() == 0);
    e.fu   = (stk.size() == DP);
    e.tz   = (stk.size() != 0) && (t == 0);
    e.cnt  = stk.size();
    e.ov   = m_ovf;
    e.un   = m_unf;
    return e;
  endfunction

  task automatic model_step(bit pu, bit po, bit t, bit c, int d);
    bit o_set = 0, u_set = 0;
    bit was_empty = (stk.size() == 0);
    if (t) begin
      if (was_empty) begin m_peek = 0; u_set = 1; end
      else m_peek = stk[stk.size()-1];
    end
    if (pu && po && !was_empty) stk[stk.size()-1] = d;
    else if (pu) begin
      if (stk.size() < DP) stk.push_back(d);
      else o_set = 1;
    end else if (po) begin
      if (was_empty) u_set = 1;
      else void'(stk.pop_back());
    end
    m_ovf = (m_ovf && !c) || o_set;
    m_unf = (m_unf && !c) || u_set;
  endtask

  task automatic model_reset();
    stk.delete();
    m_peek = 0;
    m_ovf  = 0;
    m_unf  = 0;
  endtask

  // Drive one cycle at the falling edge and queue the state expected after the next rising edge.
  task automatic cycle(bit pu, bit po, bit t, bit c, int d);
    @(negedge clk);
    push = pu; pop = po; tos = t; clr = c; din = d[DW-1:0];
    model_step(pu, po, t, c, d & 8'hFF);
    expq.push_back(snap());
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && expq.size() > 0) begin
        e = expq.pop_front();
        chk("dout",     dout,     e.dout);
        chk("peek",     peek,     e.peek);
        chk("top_zero", top_zero, e.tz);
        chk("empty",    empty,    e.em);
        chk("full",     full,     e.fu);
        chk("count",    count,    e.cnt);
        chk("ovf",      ovf,      e.ov);
        chk("unf",      unf,      e.un);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: timeout, checks %0d", checks);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int r, bias;
    bit pu, po;
    repeat (2) @(negedge clk);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    rst = 1'b0;
    model_reset();
    cycle(0, 0, 0, 0, 0);

    // push 5, push 7, pop: dout is 7 on the popping edge, then 5
    cycle(1, 0, 0, 0, 5);
    cycle(1, 0, 0, 0, 7);
    chk("latched_dout", dout, 7);
    cycle(0, 1, 0, 0, 0);
    chk("after_pop_dout", dout, 5);
    chk("after_pop_count", count, 1);
    cycle(0, 1, 0, 0, 0);

    // fill, overflow, clear
    for (int i = 0; i < 16; i++) cycle(1, 0, 0, 0, i);
    chk("fill_full", full, 1);
    cycle(1, 0, 0, 0, 99);
    chk("ovf_set", ovf, 1);
    chk("ovf_dout", dout, 15);
    chk("ovf_count", count, 16);
    cycle(1, 1, 0, 0, 42);
    chk("full_replace_count", count, 16);
    cycle(0, 0, 0, 1, 0);
    chk("ovf_clr", ovf, 0);
    for (int i = 0; i < 16; i++) cycle(0, 1, 0, 0, 0);

    // empty underflow, peek of empty, push zero
    cycle(0, 1, 0, 0, 0);
    chk("unf_set", unf, 1);
    cycle(0, 0, 1, 0, 0);
    chk("peek_empty", peek, 0);
    cycle(1, 1, 0, 1, 0);
    chk("push0_top_zero", top_zero, 1);
    chk("push0_unf_clr", unf, 0);
    cycle(0, 1, 0, 0, 0);

    // replace top of [3,9]
    cycle(1, 0, 0, 0, 3);
    cycle(1, 0, 0, 0, 9);
    cycle(1, 1, 0, 0, 4);
    chk("replace_count", count, 2);
    chk("replace_dout", dout, 4);
    cycle(0, 1, 0, 0, 0);
    chk("replace_pop_dout", dout, 3);
    cycle(0, 1, 0, 0, 0);

    // peek with pop, then asynchronous reset between edges
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 2);
    cycle(1, 0, 0, 0, 3);
    cycle(0, 1, 1, 0, 0);
    chk("tos_pop_peek", peek, 3);
    chk("tos_pop_dout", dout, 2);
    cycle(1, 0, 0, 0, 8);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_dout", dout, 0);
    chk("arst_peek", peek, 0);
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_full", full, 0);
    chk("arst_tz", top_zero, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_unf", unf, 0);
    model_reset();
    @(negedge clk);
    push = 0; pop = 0; tos = 0; clr = 0;
    rst = 1'b0;
    cycle(0, 0, 0, 0, 0);

    // random phases alternate between filling and draining bias
    bias = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 150 == 0) bias = $urandom_range(15, 85);
      r  = $urandom_range(0, 99);
      pu = (r < bias);
      po = ($urandom_range(0, 99) < (100 - bias));
      cycle(pu, po, ($urandom % 4) == 0, ($urandom % 16) == 0,
            (($urandom % 4) == 0) ? 0 : int'($urandom % 256));
    end

    cycle(0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    chk("queue_drained", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stack_unit.md
STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 The module SHALL have a parameter DATA_W, default 8: width of one stack entry.
REQ-002 The module SHALL have a parameter DEPTH, default 16: number of entries; power of two, at least 2.
REQ-003 Port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port push, input, 1 bit: write din as the new top of stack.
REQ-006 Port pop, input, 1 bit: remove the current top of stack.
REQ-007 Port tos, input, 1 bit: peek strobe; requests a registered copy of the top without changing the stack.
REQ-008 Port clr, input, 1 bit: synchronous clear of the sticky error flags.
REQ-009 Port din, input, DATA_W bits: push data.
REQ-010 Port dout, output, DATA_W bits: current top of stack (combinational from the top register); 0 when empty.
REQ-011 Port peek, output, DATA_W bits: registered top captured by tos.
REQ-012 Port top_zero, output, 1 bit: high when the stack is not empty and dout == 0.
REQ-013 Port empty, output, 1 bit: high when the count is 0.
REQ-014 Port full, output, 1 bit: high when the count equals DEPTH.
REQ-015 Port count, output, $clog2(DEPTH)+1 bits: number of valid entries.
REQ-016 Port ovf, output, 1 bit: sticky flag; a push was attempted while full.
REQ-017 Port unf, output, 1 bit: sticky flag; a pop or tos was attempted while empty.

Function
REQ-018 The block SHALL hold DEPTH x DATA_W storage registers, a stack pointer sp (0..DEPTH) and a top register; sp SHALL equal count.
REQ-019 The top register SHALL always equal mem[sp-1] when sp>0 and 0 when sp=0, so dout is valid in the same cycle that pop is asserted; a consumer may latch dout on the same edge that pops.
REQ-020 Push only, not full: mem[sp]<=din; top<=din; sp<=sp+1 -- one-cycle latency, so dout==din in the next cycle.
REQ-021 Push only, full: storage, sp and top unchanged; ovf<=1.
REQ-022 Pop only, sp>=2: sp<=sp-1; top<=mem[sp-2].
REQ-023 Pop only, sp=1: sp<=0; top<=0.
REQ-024 Pop only, empty: no state change; unf<=1.
REQ-025 Push and pop together, not empty: replace the top -- mem[sp-1]<=din; top<=din; sp unchanged; no flag set, even when full.
REQ-026 Push and pop together, empty: behave as push only; unf is not set.
REQ-027 tos, not empty: peek<=top; no change to sp or storage; tos may coincide with push or pop, and peek captures the pre-edge top.
REQ-028 tos, empty: peek<=0; unf<=1.
REQ-029 clr: ovf<=0 and unf<=0; if an error event occurs in the same cycle, set wins.
REQ-030 full SHALL be (sp==DEPTH), empty (sp==0) and top_zero (!empty && top==0), all decoded combinationally from registers.
REQ-031 sp SHALL never wrap: it saturates at 0 and DEPTH per REQ-021 and REQ-024.
REQ-032 An unknown or X value on an idle cycle (push=pop=tos=0) SHALL cause no state change.

Reset
REQ-033 On rst high, asynchronously: sp=0, top=0, peek=0, ovf=0, unf=0; therefore dout=0, empty=1, full=0, top_zero=0, count=0.
REQ-034 Storage contents SHALL NOT be reset; they are unobservable while empty.
REQ-035 rst asserted mid-operation SHALL abort any in-flight push or pop with no partial update after rst is released.

Verification
REQ-036 Sequence push 5, push 7, then pop with a consumer latching dout on the same edge -> latched 7; then dout=5, count=1.
REQ-037 DEPTH=16: push 0..15 -> full=1; push 99 -> ovf=1, dout=15, count=16; then clr -> ovf=0.
REQ-038 Empty: pop -> unf=1, count=0; tos -> peek=0; push 0 -> top_zero=1, empty=0.
REQ-039 Stack [3,9] (9 on top): push+pop with din=4 -> count=2, dout=4; pop -> dout=3.
REQ-040 Push 1, 2, 3; tos with simultaneous pop -> peek=3, dout=2; then assert rst mid-cycle -> all outputs at reset values immediately.
